mult_share_rr: RTL and testbench

Round-robin scheduler that shares one pipelined 16x16 unsigned multiplier among NUM_REQ independent requesters. Each requester presents operands on a valid/ready channel. The block grants one requester per cycle, tags the operation with the requester index, and carries it through an enable-gated multiplier pipeline. Results leave on a single tagged response channel with backpressure. It sits between client engines (filters, accumulators) and the shared multiplier datapath.

---
 rtl/mult_share_pkg.sv | 42 ++++
 rtl/mult_pipe.sv | 80 ++++++++
 rtl/mult_share_rr.sv | 92 +++++++++
 tb/tb_mult_share_rr.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared constants, stage record and round-robin pick helper
// for the shared multiplier scheduler.
package mult_share_pkg;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 16;
    localparam int MUL_LAT = 2;
    localparam int ID_W    = $clog2(NUM_REQ);

    // Widest supported arbiter, used to size the pick helper.
    localparam int MAX_REQ = 8;
    localparam int MAX_IW  = 3;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
    } stage_t;

    // Returns {found, index}. Search starts one past 'last' and
    // wraps modulo n; the nearest valid requester wins.
    function automatic logic [MAX_IW:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [MAX_IW-1:0]  last,
        input int                 n
    );
        logic [MAX_IW:0]   r;
        logic [MAX_IW-1:0] idx;
        r = '0;
        for (int i = MAX_REQ; i >= 1; i--) begin
            if (i <= n) begin
                idx = MAX_IW'((int'(last) + i) % n);
                if (valid[idx]) begin
                    r = {1'b1, idx};
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_pipe.sv
// Enable-gated unsigned multiplier pipeline carrying a valid bit
// and a requester tag; the whole pipe advances only when i_en.
module mult_pipe #(
    parameter int WIDTH   = 16,
    parameter int MUL_LAT = 2,
    parameter int IW      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_valid,
    input  logic [IW-1:0]      i_id,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_valid,
    output logic [IW-1:0]      o_id,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_busy
);
    import mult_share_pkg::*;

    localparam int PW = 2 * WIDTH;

    logic                        r_v0;
    logic [IW-1:0]               r_id0;
    logic [WIDTH-1:0]            r_a;
    logic [WIDTH-1:0]            r_b;

    logic [MUL_LAT-1:0]          w_v;
    logic [MUL_LAT-1:0][IW-1:0]  w_id;
    logic [MUL_LAT-1:0][PW-1:0]  w_p;

    // Stage 0 captures the granted operation (or a bubble).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0  <= 1'b0;
            r_id0 <= '0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (i_en) begin
            r_v0  <= i_valid;
            r_id0 <= i_id;
            r_a   <= i_a;
            r_b   <= i_b;
        end
    end

    assign w_v[0]  = r_v0;
    assign w_id[0] = r_id0;
    assign w_p[0]  = PW'(r_a) * PW'(r_b);

    for (genvar k = 1; k < MUL_LAT; k++) begin : g_stg
        logic          r_v;
        logic [IW-1:0] r_id;
        logic [PW-1:0] r_p;

        // Product stage k: shift forward in lockstep with stage 0.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v  <= 1'b0;
                r_id <= '0;
                r_p  <= '0;
            end else if (i_en) begin
                r_v  <= w_v[k-1];
                r_id <= w_id[k-1];
                r_p  <= w_p[k-1];
            end
        end

        assign w_v[k]  = r_v;
        assign w_id[k] = r_id;
        assign w_p[k]  = r_p;
    end

    assign o_valid   = w_v[MUL_LAT-1];
    assign o_id      = w_id[MUL_LAT-1];
    assign o_product = w_p[MUL_LAT-1];
    assign o_busy    = |w_v;

endmodule

// File: rtl/mult_share_rr.sv
// Round-robin front end sharing one pipelined multiplier among
// NUM_REQ requesters, with a single tagged result channel.
module mult_share_rr #(
    parameter int NUM_REQ = mult_share_pkg::NUM_REQ,
    parameter int WIDTH   = mult_share_pkg::WIDTH,
    parameter int MUL_LAT = mult_share_pkg::MUL_LAT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(NUM_REQ)-1:0] out_id,
    output logic [2*WIDTH-1:0]         out_product,
    output logic                       busy
);
    import mult_share_pkg::*;

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]      r_last;

    logic               w_adv;
    logic               w_xfer;
    logic               w_found;
    logic [MAX_REQ-1:0] w_vext;
    logic [MAX_IW-1:0]  w_lext;
    logic [MAX_IW:0]    w_pick;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_gidx;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;

    // The pipe may move whenever the output slot is free or draining.
    assign w_adv   = !out_valid || out_ready;
    assign w_found = w_pick[MAX_IW];
    assign w_xfer  = w_found && w_adv && !rst;

    // Round-robin pick plus one-hot grant, index and operand mux.
    always_comb begin
        w_vext = '0;
        w_vext[NUM_REQ-1:0] = req_valid;
        w_lext = '0;
        w_lext[IW-1:0] = r_last;
        w_pick = rr_pick(w_vext, w_lext, NUM_REQ);
        w_gnt  = '0;
        w_gidx = '0;
        w_a    = '0;
        w_b    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_found && (w_pick[MAX_IW-1:0] == MAX_IW'(i))) begin
                w_gnt[i] = 1'b1;
                w_gidx   = IW'(i);
                w_a      = req_a[i*WIDTH +: WIDTH];
                w_b      = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign req_ready = w_gnt & {NUM_REQ{w_adv && !rst}};

    // Pointer moves only on a real transfer, never on a stalled grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= IW'(NUM_REQ - 1);
        end else if (w_xfer) begin
            r_last <= w_gidx;
        end
    end

    mult_pipe #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT),
        .IW      (IW)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_adv),
        .i_valid   (w_xfer),
        .i_id      (w_gidx),
        .i_a       (w_a),
        .i_b       (w_b),
        .o_valid   (out_valid),
        .o_id      (out_id),
        .o_product (out_product),
        .o_busy    (busy)
    );

endmodule

// File: tb/tb_mult_share_rr.sv
// Directed self-checking bench for mult_share_rr
// (NUM_REQ=4, WIDTH=16, MUL_LAT=2).
module tb_mult_share_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_id;
    logic [31:0] out_product;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    mult_share_rr #(
        .NUM_REQ (4),
        .WIDTH   (16),
        .MUL_LAT (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_id      (out_id),
        .out_product (out_product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic set_op(input int i, input logic [15:0] a,
                          input logic [15:0] b);
        req_a[i*16 +: 16] = a;
        req_b[i*16 +: 16] = b;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'hF;
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'h0) begin
            failures++;
            $display("FAIL rst_ready act=%h exp=0", req_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_valid_busy act=%b%b exp=00", out_valid, busy);
        end
        checks++;
        if (out_id !== 2'd0 || out_product !== 32'd0) begin
            failures++;
            $display("FAIL rst_data act=%0d/%h exp=0/0", out_id, out_product);
        end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single_op;
        do_reset();
        @(negedge clk);
        set_op(2, 16'hFFFF, 16'hFFFF);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_ready act=%b exp=0100", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_mid act=%b%b exp=01", out_valid, busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2 ||
            out_product !== 32'hFFFE0001) begin
            failures++;
            $display("FAIL single_out act=%b/%0d/%h exp=1/2/fffe0001",
                     out_valid, out_id, out_product);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_drain act=%b%b exp=00", out_valid, busy);
        end
    endtask

    task automatic test_round_robin;
        logic [15:0] ta [4] = '{16'd3, 16'd7, 16'd11, 16'd250};
        logic [15:0] tb [4] = '{16'd5, 16'd13, 16'd1000, 16'hABCD};
        logic [3:0]  eg;
        logic [31:0] ep;
        int          id;
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, ta[i], tb[i]);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                eg = 4'b0001 << (c % 4);
                checks++;
                if (req_ready !== eg) begin
                    failures++;
                    $display("FAIL rr_grant c=%0d act=%b exp=%b", c, req_ready, eg);
                end
            end
            if (c >= 2 && c < 10) begin
                id = (c - 2) % 4;
                ep = 32'(ta[id]) * 32'(tb[id]);
                checks++;
                if (out_valid !== 1'b1 || out_id !== 2'(id) ||
                    out_product !== ep) begin
                    failures++;
                    $display("FAIL rr_out c=%0d act=%b/%0d/%h exp=1/%0d/%h",
                             c, out_valid, out_id, out_product, id, ep);
                end
            end
            if (c >= 10) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rr_extra c=%0d act=%b exp=0", c, out_valid);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        int          tx = 0;
        int          rx = 0;
        int          cyc = 0;
        bit          adv;
        bit          pstall = 0;
        logic [1:0]  pid = '0;
        logic [31:0] pprod = '0;
        logic [31:0] ep;
        logic [3:0]  er;
        do_reset();
        while (rx < 10 && cyc < 200) begin
            @(negedge clk);
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            req_valid = (tx < 10) ? 4'b0010 : 4'b0000;
            set_op(1, 16'(tx), 16'(tx + 1));
            #1;
            adv = !out_valid || out_ready;
            er  = (tx < 10 && adv) ? 4'b0010 : 4'b0000;
            checks++;
            if (req_ready !== er) begin
                failures++;
                $display("FAIL bp_ready cyc=%0d act=%b exp=%b", cyc, req_ready, er);
            end
            if (pstall) begin
                checks++;
                if (out_valid !== 1'b1 || out_id !== pid ||
                    out_product !== pprod) begin
                    failures++;
                    $display("FAIL bp_stable cyc=%0d act=%b/%0d/%h exp=1/%0d/%h",
                             cyc, out_valid, out_id, out_product, pid, pprod);
                end
            end
            if (out_valid === 1'b1) begin
                ep = 32'(rx * (rx + 1));
                checks++;
                if (out_id !== 2'd1 || out_product !== ep) begin
                    failures++;
                    $display("FAIL bp_result k=%0d act=%0d/%h exp=1/%h",
                             rx, out_id, out_product, ep);
                end
                if (out_ready) rx++;
            end
            pstall = (out_valid === 1'b1) && !out_ready;
            pid    = out_id;
            pprod  = out_product;
            if (req_ready[1] === 1'b1) tx++;
            cyc++;
        end
        checks++;
        if (rx != 10) begin
            failures++;
            $display("FAIL bp_count act=%0d exp=10", rx);
        end
        req_valid = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL bp_dup c=%0d act=%b exp=0", c, out_valid);
            end
        end
    endtask

    task automatic test_withdrawn(input bit hold3);
        logic [3:0]  eg;
        logic [1:0]  eid;
        logic [31:0] ep;
        do_reset();
        out_ready = 1'b0;
        set_op(2, 16'd9, 16'd9);
        set_op(3, 16'd3, 16'd1000);
        set_op(0, 16'd2, 16'd50);
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL wd_first act=%b exp=0100", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || out_valid !== 1'b1 ||
            out_product !== 32'd81) begin
            failures++;
            $display("FAIL wd_stall1 act=%b/%b/%h exp=0000/1/51",
                     req_ready, out_valid, out_product);
        end
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL wd_stall2 act=%b exp=0000", req_ready);
        end
        @(negedge clk);
        out_ready = 1'b1;
        req_valid = hold3 ? 4'b1001 : 4'b0001;
        eg  = hold3 ? 4'b1000 : 4'b0001;
        eid = hold3 ? 2'd3 : 2'd0;
        ep  = hold3 ? 32'd3000 : 32'd100;
        #1;
        checks++;
        if (req_ready !== eg) begin
            failures++;
            $display("FAIL wd_release hold3=%0d act=%b exp=%b", hold3, req_ready, eg);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_id !== eid || out_product !== ep) begin
            failures++;
            $display("FAIL wd_result act=%b/%0d/%h exp=1/%0d/%h",
                     out_valid, out_id, out_product, eid, ep);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight;
        do_reset();
        set_op(1, 16'd10, 16'd10);
        set_op(2, 16'd20, 16'd20);
        set_op(3, 16'd30, 16'd30);
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            req_valid = 4'b0001 << c;
        end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre act=%b%b exp=11", busy, out_valid);
        end
        #2;
        rst       = 1'b1;
        req_valid = 4'hF;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'h0) begin
            failures++;
            $display("FAIL mid_rst act=%b/%b/%b exp=0/0/0000",
                     out_valid, busy, req_ready);
        end
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 4'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_stale c=%0d act=%b%b exp=00", c, out_valid, busy);
            end
        end
        @(negedge clk);
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_first act=%b exp=0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_boundary;
        logic [31:0] ep [3] = '{32'd0, 32'h00008000, 32'h40000000};
        do_reset();
        set_op(0, 16'h0000, 16'hFFFF);
        set_op(1, 16'h0001, 16'h8000);
        set_op(2, 16'h8000, 16'h8000);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = (c < 3) ? (4'b0001 << c) : 4'b0000;
            #1;
            if (c >= 2 && c < 5) begin
                checks++;
                if (out_valid !== 1'b1 || out_id !== 2'(c - 2) ||
                    out_product !== ep[c-2]) begin
                    failures++;
                    $display("FAIL bnd_out i=%0d act=%b/%0d/%h exp=1/%0d/%h",
                             c - 2, out_valid, out_id, out_product, c - 2, ep[c-2]);
                end
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        out_ready = 1'b1;
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_withdrawn(1'b1);
        test_withdrawn(1'b0);
        test_reset_midflight();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
